// File: rtl/rv_cpu_top_core.sv
// ============================================================================
// rv_cpu_top_core
// ----------------------------------------------------------------------------
// Minimal single-cycle RV32I-subset CPU with a built-in instruction ROM.
// The ROM holds a fixed program that walks a 16-bit Galois LFSR
// (taps 0xB400, seed 0xACE1) and publishes each value through a
// memory-mapped store to OUT_ADDR, which lands in Data_out.
//
// Every rising edge with rst=1 completes exactly one instruction
// (fetch, decode, execute and writeback in the same cycle, CPI = 1).
//
// Supported: LUI, ADDI/ANDI/ORI/XORI/SLLI/SRLI, ADD/SUB/AND/OR/XOR,
//            BEQ/BNE, JAL, SW. Any other encoding behaves as a NOP.
//
// Parameters
//   ROM_WORDS : instruction ROM depth in 32-bit words (power of two)
//   OUT_ADDR  : store address mapped onto Data_out
//   RESET_PC  : PC value after reset
//
// Ports
//   clk      in   1   single clock, rising-edge state updates
//   rst      in   1   asynchronous active-low reset (0 = in reset)
//   Data_out out  32  output register, written by SW to OUT_ADDR
// ============================================================================
module rv_cpu_top_core #(
    parameter int unsigned ROM_WORDS = 64,
    parameter logic [31:0] OUT_ADDR  = 32'h0000_0100,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] Data_out
);

    // ------------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------------
    localparam int unsigned IDX_W   = (ROM_WORDS > 1) ? $clog2(ROM_WORDS) : 1;
    localparam logic [31:0] PC_MASK = 32'(ROM_WORDS * 4) - 32'd1;
    localparam logic [31:0] NOP_W   = 32'h0000_0013;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011,
        OPC_BRANCH = 7'b1100011,
        OPC_JAL    = 7'b1101111,
        OPC_STORE  = 7'b0100011
    } opcode_e;

    // ------------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------------
    logic [31:0] pc_q, pc_d;
    logic [31:0] rf_q [0:31];
    logic [31:0] data_out_q, data_out_d;

    assign Data_out = data_out_q;

    // ------------------------------------------------------------------------
    // Instruction ROM (combinational, indexed by the word address)
    // ------------------------------------------------------------------------
    logic [IDX_W-1:0] rom_idx;
    logic [31:0]      instr;

    assign rom_idx = pc_q[IDX_W+1:2];

    always_comb begin
        instr = NOP_W;
        case (rom_idx)
            IDX_W'(0):  instr = 32'h0000_B2B7; // lui  x5,0xB
            IDX_W'(1):  instr = 32'h4002_8293; // addi x5,x5,1024   -> 0xB400
            IDX_W'(2):  instr = 32'h0000_B0B7; // lui  x1,0xB
            IDX_W'(3):  instr = 32'hCE10_8093; // addi x1,x1,-799   -> 0xACE1
            IDX_W'(4):  instr = 32'h1010_2023; // sw   x1,0x100(x0)
            IDX_W'(5):  instr = 32'h0010_F193; // andi x3,x1,1
            IDX_W'(6):  instr = 32'h0010_D093; // srli x1,x1,1
            IDX_W'(7):  instr = 32'h0001_8463; // beq  x3,x0,+8
            IDX_W'(8):  instr = 32'h0050_C0B3; // xor  x1,x1,x5
            IDX_W'(9):  instr = 32'hFEDF_F06F; // jal  x0,-20
            default:    instr = NOP_W;
        endcase
    end

    // ------------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------------
    opcode_e     opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    logic [31:0] rs1_val, rs2_val;

    assign opcode = opcode_e'(instr[6:0]);
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                    instr[30:21], 1'b0};
    assign imm_u = {instr[31:12], 12'h000};

    // x0 is hardwired to zero on the read side as well as the write side
    assign rs1_val = (rs1 == 5'd0) ? '0 : rf_q[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : rf_q[rs2];

    // ------------------------------------------------------------------------
    // Execute: ALU, branch resolution, next PC, writeback and store
    // ------------------------------------------------------------------------
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic        rd_we;
    logic [31:0] rd_wdata;
    logic [31:0] st_addr;
    logic        out_we;

    assign pc_plus4 = pc_q + 32'd4;
    assign st_addr  = rs1_val + imm_s;

    always_comb begin
        pc_next  = pc_plus4;
        rd_we    = 1'b0;
        rd_wdata = '0;
        out_we   = 1'b0;

        case (opcode)
            OPC_LUI: begin
                rd_we    = 1'b1;
                rd_wdata = imm_u;
            end

            OPC_OP_IMM: begin
                case (funct3)
                    3'b000: begin
                        rd_we    = 1'b1;
                        rd_wdata = rs1_val + imm_i;
                    end
                    3'b111: begin
                        rd_we    = 1'b1;
                        rd_wdata = rs1_val & imm_i;
                    end
                    3'b110: begin
                        rd_we    = 1'b1;
                        rd_wdata = rs1_val | imm_i;
                    end
                    3'b100: begin
                        rd_we    = 1'b1;
                        rd_wdata = rs1_val ^ imm_i;
                    end
                    3'b001: begin
                        if (funct7 == 7'b0000000) begin
                            rd_we    = 1'b1;
                            rd_wdata = rs1_val << imm_i[4:0];
                        end
                    end
                    3'b101: begin
                        // SRAI (funct7=0100000) is not supported and falls to NOP
                        if (funct7 == 7'b0000000) begin
                            rd_we    = 1'b1;
                            rd_wdata = rs1_val >> imm_i[4:0];
                        end
                    end
                    default: ;
                endcase
            end

            OPC_OP: begin
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: begin
                        rd_we    = 1'b1;
                        rd_wdata = rs1_val + rs2_val;
                    end
                    {7'b0100000, 3'b000}: begin
                        rd_we    = 1'b1;
                        rd_wdata = rs1_val - rs2_val;
                    end
                    {7'b0000000, 3'b111}: begin
                        rd_we    = 1'b1;
                        rd_wdata = rs1_val & rs2_val;
                    end
                    {7'b0000000, 3'b110}: begin
                        rd_we    = 1'b1;
                        rd_wdata = rs1_val | rs2_val;
                    end
                    {7'b0000000, 3'b100}: begin
                        rd_we    = 1'b1;
                        rd_wdata = rs1_val ^ rs2_val;
                    end
                    default: ;
                endcase
            end

            OPC_BRANCH: begin
                case (funct3)
                    3'b000: if (rs1_val == rs2_val) pc_next = pc_q + imm_b;
                    3'b001: if (rs1_val != rs2_val) pc_next = pc_q + imm_b;
                    default: ;
                endcase
            end

            OPC_JAL: begin
                rd_we    = 1'b1;
                rd_wdata = pc_plus4;
                pc_next  = pc_q + imm_j;
            end

            OPC_STORE: begin
                // No data memory: only the mapped output address has an effect
                if (funct3 == 3'b010 && st_addr == OUT_ADDR) begin
                    out_we = 1'b1;
                end
            end

            default: ;
        endcase
    end

    // PC wraps inside the ROM address space
    assign pc_d       = pc_next & PC_MASK;
    assign data_out_d = out_we ? rs2_val : data_out_q;

    // ------------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            data_out_q <= '0;
            for (int unsigned i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            data_out_q <= data_out_d;
            if (rd_we && rd != 5'd0) begin
                rf_q[rd] <= rd_wdata;
            end
        end
    end

endmodule

// File: tb/tb_rv_cpu_top_core.sv
// ============================================================================
// tb_rv_cpu_top_core
// ----------------------------------------------------------------------------
// Scoreboard bench: the stimulus process pushes expected stores
// (value and the edge count since reset release) into a queue, and a
// monitor pops and compares whenever Data_out changes.
// ============================================================================
module tb_rv_cpu_top_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] data_out;

    always #2 clk = ~clk;

    rv_cpu_top_core #(
        .ROM_WORDS (64),
        .OUT_ADDR  (32'h0000_0100),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .Data_out (data_out)
    );

    typedef struct {
        logic [31:0] val;
        int          at_edge;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_checks  = 0;
    int          n_pass    = 0;
    int          edge_cnt  = 0;
    logic [31:0] prev_out  = '0;
    bit          chk_range = 1'b0;

    // Rising edges with rst high since the last reset release
    always @(posedge clk or negedge rst) begin
        if (!rst) edge_cnt <= 0;
        else      edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? 32'h0000_B400 : 32'h0);
    endfunction

    // Monitor: every change of Data_out must match the head of the scoreboard
    always @(negedge clk) begin
        if (data_out !== prev_out) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_store: got %h expected no change (edge %0d)",
                         data_out, edge_cnt);
            end else begin
                mon_e = sb_q.pop_front();
                check("store_value", data_out, mon_e.val);
                check("store_edge", 32'(edge_cnt), 32'(mon_e.at_edge));
            end
            if (chk_range) begin
                check("store_below_0x10000", {16'h0, data_out[31:16]}, 32'h0);
                n_checks++;
                if (data_out != 32'h0) n_pass++;
                else $display("FAIL store_nonzero: got %h expected nonzero", data_out);
            end
            prev_out = data_out;
        end
    end

    // Hand-computed first loop: value and rising edge after release
    logic [31:0] dir_val  [7] = '{32'hACE1, 32'hE270, 32'h7138, 32'h389C,
                                  32'h1C4E, 32'h0E27, 32'hB313};
    int          dir_edge [7] = '{5, 11, 16, 21, 26, 31, 37};

    initial begin
        logic [31:0] v;
        int          e;
        int          last_edge;

        // Reset held for 27 ns: nothing may execute
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_data_out", data_out, 32'h0);
            check("rst_pc", dut.pc_q, 32'h0);
            check("rst_x1", dut.rf_q[1], 32'h0);
        end
        #3;
        for (int i = 0; i < 7; i++) sb_q.push_back('{dir_val[i], dir_edge[i]});
        rst = 1'b1;

        // Run through edge 40: just after the beq following the 0xB313 store
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("pc_edge40", dut.pc_q, 32'h0000_0020);
        check("x5_taps", dut.rf_q[5], 32'h0000_B400);
        check("queue_drained_1", 32'(sb_q.size()), 32'h0);

        // Mid-sequence reset: clears asynchronously
        #1;
        sb_q.push_back('{32'h0, 0});
        rst = 1'b0;
        #1;
        check("async_clear_data", data_out, 32'h0);
        check("async_clear_pc", dut.pc_q, 32'h0);
        check("async_clear_x1", dut.rf_q[1], 32'h0);
        repeat (3) @(negedge clk);
        #1;

        // Restart: model-generated chain starting at the seed
        v = 32'hACE1;
        e = 5;
        last_edge = 5;
        for (int i = 0; i < 18; i++) begin
            sb_q.push_back('{v, e});
            last_edge = e;
            e = e + (v[0] ? 6 : 5);
            v = lfsr_next(v);
        end
        chk_range = 1'b1;
        rst = 1'b1;

        repeat (last_edge + 1) @(posedge clk);
        @(negedge clk);
        #1;
        check("queue_drained_2", 32'(sb_q.size()), 32'h0);
        while (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_checks++;
            $display("FAIL missing_store: got none expected %h at edge %0d",
                     mon_e.val, mon_e.at_edge);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
